// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: distance countdown, game-phase FSM, LFSR-driven coin/barrier releases.
// Optional build macro DOUBLE_SPAWN_EN: each spawn also releases the other object in the next lane.
module obstacle_scheduler #(
  parameter int START_DISTANCE   = 200,
  parameter int FRAMES_PER_METER = 64,
  parameter int SPAWN_INTERVAL   = 20,
  parameter int REFRESH_FRAMES   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_tick,
  input  logic        i_game_switch,
  input  logic        i_zero_lives,
  input  logic        i_penguin_hit,
  input  logic        i_coin_hit,
  output logic [11:0] o_distance,
  output logic [1:0]  o_state,
  output logic [1:0]  o_release_coin,
  output logic [1:0]  o_release_barrier,
  output logic [2:0]  o_active_led,
  output logic        o_sprite_refresh
);

  localparam int FW = (FRAMES_PER_METER > 1) ? $clog2(FRAMES_PER_METER) : 1;
  localparam int MW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int RW = (REFRESH_FRAMES > 1) ? $clog2(REFRESH_FRAMES) : 1;

  localparam logic [FW-1:0] FRAME_LAST   = FW'(FRAMES_PER_METER - 1);
  localparam logic [MW-1:0] METER_LAST   = MW'(SPAWN_INTERVAL - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_FRAMES - 1);
  localparam logic [11:0]   DIST_INIT    = 12'(START_DISTANCE);
  localparam logic [7:0]    LFSR_SEED    = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [11:0]     distance_reg;
  logic [FW-1:0]   frame_cnt_reg;
  logic [MW-1:0]   meter_cnt_reg;
  logic [RW-1:0]   refresh_cnt_reg;
  logic            refresh_reg;
  logic [7:0]      lfsr_reg;
  logic [1:0]      coin_reg, barrier_reg;

  logic            run_tick, frame_wrap, meter_step, dist_hits_zero, spawn_en, restart;
  logic            lfsr_fb;
  logic [1:0]      spawn_lane, other_lane;

  assign run_tick       = (state_reg == RUN) && i_frame_tick && !i_zero_lives;
  assign frame_wrap     = run_tick && (frame_cnt_reg == FRAME_LAST);
  assign meter_step     = frame_wrap && (distance_reg != 12'd0);
  assign dist_hits_zero = meter_step && (distance_reg == 12'd1);
  // A spawn on the final metre is dropped: reaching FINISH takes precedence.
  assign spawn_en       = meter_step && (meter_cnt_reg == METER_LAST) && !dist_hits_zero;
  assign restart        = (state_reg == FINISH) && (state_next == IDLE);

  assign lfsr_fb    = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign spawn_lane = (lfsr_reg[1:0] == 2'b00) ? 2'b10 : lfsr_reg[1:0];
  assign other_lane = (spawn_lane == 2'b11) ? 2'b01 : spawn_lane + 2'd1;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (i_zero_lives) begin
      state_next = FINISH;
    end else begin
      case (state_reg)
        IDLE:   if (i_game_switch) state_next = RUN;
        RUN: begin
          if (!i_game_switch)                                state_next = PAUSE;
          else if (dist_hits_zero || distance_reg == 12'd0)  state_next = FINISH;
        end
        PAUSE:  if (i_game_switch) state_next = RUN;
        FINISH: if (!i_game_switch) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_state           = state_reg;
    o_distance        = distance_reg;
    o_sprite_refresh  = refresh_reg;
    o_release_coin    = coin_reg;
    o_release_barrier = i_penguin_hit ? 2'b00 : barrier_reg;
    if (o_release_barrier != 2'b00)   o_active_led = 3'b100;
    else if (o_release_coin != 2'b00) o_active_led = 3'b110;
    else                              o_active_led = 3'b010;
  end

  // Distance, frame/metre/refresh counters and LFSR; frozen outside RUN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      distance_reg    <= DIST_INIT;
      frame_cnt_reg   <= '0;
      meter_cnt_reg   <= '0;
      refresh_cnt_reg <= '0;
      refresh_reg     <= 1'b0;
      lfsr_reg        <= LFSR_SEED;
    end else if (restart) begin
      distance_reg    <= DIST_INIT;
      frame_cnt_reg   <= '0;
      meter_cnt_reg   <= '0;
      refresh_cnt_reg <= '0;
      refresh_reg     <= 1'b0;
    end else if (run_tick) begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
      frame_cnt_reg <= frame_wrap ? '0 : frame_cnt_reg + FW'(1);
      if (meter_step) begin
        distance_reg  <= distance_reg - 12'd1;
        meter_cnt_reg <= (meter_cnt_reg == METER_LAST) ? '0 : meter_cnt_reg + MW'(1);
      end
      if (refresh_cnt_reg == REFRESH_LAST) begin
        refresh_cnt_reg <= '0;
        refresh_reg     <= ~refresh_reg;
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg + RW'(1);
      end
    end
  end

  // Release registers: a spawn overrides a same-edge hit, which refers to the old object.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      coin_reg    <= 2'b00;
      barrier_reg <= 2'b00;
    end else if (state_next == FINISH) begin
      coin_reg    <= 2'b00;
      barrier_reg <= 2'b00;
    end else if (spawn_en) begin
      if (lfsr_reg[2]) begin
        barrier_reg <= spawn_lane;
`ifdef DOUBLE_SPAWN_EN
        coin_reg    <= other_lane;
`else
        coin_reg    <= 2'b00;
`endif
      end else begin
        coin_reg    <= spawn_lane;
`ifdef DOUBLE_SPAWN_EN
        barrier_reg <= other_lane;
`else
        barrier_reg <= 2'b00;
`endif
      end
    end else if (state_reg != PAUSE) begin
      if (i_penguin_hit) barrier_reg <= 2'b00;
      if (i_coin_hit)    coin_reg    <= 2'b00;
    end
  end

`ifndef DOUBLE_SPAWN_EN
  logic unused_other_lane;
  assign unused_other_lane = ^other_lane;
`endif

endmodule
